// File: rtl/nec_pkg.sv
// Shared NEC protocol timing (in 56.25 us nec_clk ticks) and transmitter state encoding.
// irReceiver thresholds derive from the same constants.
package nec_pkg;

   localparam int NEC_TICK_NS = 56250;

   localparam int LEAD_MARK  = 160;
   localparam int LEAD_SPACE = 80;
   localparam int RPT_SPACE  = 40;
   localparam int BIT_MARK   = 10;
   localparam int ZERO_SPACE = 10;
   localparam int ONE_SPACE  = 30;
   localparam int GAP_TICKS  = 711;

   localparam int CNT_W   = 10;
   localparam int CNT_MAX = (2 ** CNT_W) - 1;

   typedef enum logic [2:0] {
      IDLE,
      LMARK,
      LSPACE,
      BMARK,
      BSPACE,
      SMARK,
      GAP
   } tx_state_t;

   // A state lasting n ticks loads n-1 and leaves when the counter reads 0.
   function automatic logic [CNT_W-1:0] ticks_ld(input int n);
      return CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/nec_tick_timer.sv
// Loadable down-counter timing each NEC symbol; holds at zero until reloaded.
module nec_tick_timer #(
   parameter int W = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic [W-1:0] count_o,
   output logic         expired_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o   = count_q;
   assign expired_o = (count_q == '0);

endmodule

// File: rtl/nec_ir_transmitter.sv
// NEC IR frame generator: leader, 32 data bits MSB-first (or repeat code), stop burst, gap.
// ir_signal is baseband and active low; marks drive it to 0.
module nec_ir_transmitter
   import nec_pkg::*;
(
   input  logic        nec_clk,
   input  logic        reset,
   input  logic        start,
   input  logic        rpt,
   input  logic [31:0] code,
   output logic        ready,
   output logic        done,
   output logic        ir_signal
);

   if (LEAD_MARK > CNT_MAX || LEAD_SPACE > CNT_MAX || RPT_SPACE > CNT_MAX ||
       BIT_MARK > CNT_MAX || ZERO_SPACE > CNT_MAX || ONE_SPACE > CNT_MAX ||
       GAP_TICKS > CNT_MAX || LEAD_MARK < 1 || LEAD_SPACE < 1 || RPT_SPACE < 1 ||
       BIT_MARK < 1 || ZERO_SPACE < 1 || ONE_SPACE < 1 || GAP_TICKS < 1) begin : g_param_check
      $error("nec_ir_transmitter: timing constant outside 1..1023");
   end

   tx_state_t        state_q;
   logic [31:0]      code_q;
   logic             rpt_q;
   logic [4:0]       idx_q;
   logic             ready_q;
   logic             done_q;
   logic             ir_q;

   logic             tmr_load;
   logic [CNT_W-1:0] tmr_load_val;
   logic [CNT_W-1:0] tmr_count;
   logic             tmr_expired;
   logic             accept;

   assign accept = start && ready_q;

   nec_tick_timer #(
      .W (CNT_W)
   ) u_timer (
      .clk_i      (nec_clk),
      .rst_i      (reset),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .count_o    (tmr_count),
      .expired_o  (tmr_expired)
   );

   // Reload value is the duration of the state being entered.
   always_comb begin
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      case (state_q)
         IDLE: begin
            tmr_load     = accept;
            tmr_load_val = ticks_ld(LEAD_MARK);
         end
         LMARK: begin
            tmr_load     = tmr_expired;
            tmr_load_val = rpt_q ? ticks_ld(RPT_SPACE) : ticks_ld(LEAD_SPACE);
         end
         LSPACE, BSPACE: begin
            tmr_load     = tmr_expired;
            tmr_load_val = ticks_ld(BIT_MARK);
         end
         BMARK: begin
            tmr_load     = tmr_expired;
            tmr_load_val = code_q[idx_q] ? ticks_ld(ONE_SPACE) : ticks_ld(ZERO_SPACE);
         end
         SMARK: begin
            tmr_load     = tmr_expired;
            tmr_load_val = ticks_ld(GAP_TICKS);
         end
         default: begin
            tmr_load     = 1'b0;
            tmr_load_val = '0;
         end
      endcase
   end

   always_ff @(posedge nec_clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         code_q  <= '0;
         rpt_q   <= 1'b0;
         idx_q   <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         ir_q    <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  code_q  <= code;
                  rpt_q   <= rpt;
                  ready_q <= 1'b0;
                  ir_q    <= 1'b0;
                  state_q <= LMARK;
               end
            end
            LMARK: begin
               if (tmr_expired) begin
                  ir_q    <= 1'b1;
                  state_q <= LSPACE;
               end
            end
            LSPACE: begin
               if (tmr_expired) begin
                  ir_q <= 1'b0;
                  if (rpt_q) begin
                     state_q <= SMARK;
                     done_q  <= (BIT_MARK == 1);
                  end else begin
                     idx_q   <= 5'd31;
                     state_q <= BMARK;
                  end
               end
            end
            BMARK: begin
               if (tmr_expired) begin
                  ir_q    <= 1'b1;
                  state_q <= BSPACE;
               end
            end
            BSPACE: begin
               if (tmr_expired) begin
                  ir_q <= 1'b0;
                  if (idx_q != 5'd0) begin
                     idx_q   <= idx_q - 5'd1;
                     state_q <= BMARK;
                  end else begin
                     state_q <= SMARK;
                     done_q  <= (BIT_MARK == 1);
                  end
               end
            end
            SMARK: begin
               // done is registered, so raise it one cycle ahead of the final tick
               if (!tmr_expired && tmr_count == CNT_W'(1)) begin
                  done_q <= 1'b1;
               end
               if (tmr_expired) begin
                  ir_q    <= 1'b1;
                  state_q <= GAP;
               end
            end
            GAP: begin
               if (tmr_expired) begin
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               ir_q    <= 1'b1;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign ir_signal = ir_q;

endmodule

// File: tb/tb_nec_ir_transmitter.sv
// Directed bench: captures ir_signal as run lengths, decodes it like a receiver and
// compares against hand-derived NEC frame timings.
`timescale 1ns/1ps
module tb_nec_ir_transmitter;

   localparam int HALF_NS = 28125;

   logic        nec_clk;
   logic        reset;
   logic        start;
   logic        rpt;
   logic [31:0] code;
   logic        ready;
   logic        done;
   logic        ir_signal;

   int nchecks = 0;
   int nerrors = 0;

   int   run_q[$];
   int   exp_q[$];
   logic first_lvl;
   int   done_cnt;
   int   done_tick;
   int   ready_tick;

   nec_ir_transmitter dut (
      .nec_clk   (nec_clk),
      .reset     (reset),
      .start     (start),
      .rpt       (rpt),
      .code      (code),
      .ready     (ready),
      .done      (done),
      .ir_signal (ir_signal)
   );

   initial nec_clk = 1'b0;
   always #(HALF_NS) nec_clk = ~nec_clk;

   function automatic int get_run(input int i);
      if (i < 0 || i >= run_q.size()) return -1;
      return run_q[i];
   endfunction

   function automatic int get_exp(input int i);
      if (i < 0 || i >= exp_q.size()) return -1;
      return exp_q[i];
   endfunction

   // Expected run lengths: leader mark/space, bit mark/space pairs, stop mark, gap.
   function automatic void build_expected(input logic [31:0] c, input logic r);
      exp_q.delete();
      exp_q.push_back(160);
      exp_q.push_back(r ? 40 : 80);
      if (!r) begin
         for (int i = 31; i >= 0; i--) begin
            exp_q.push_back(10);
            exp_q.push_back(c[i] ? 30 : 10);
         end
      end
      exp_q.push_back(10);
      exp_q.push_back(711);
   endfunction

   function automatic int first_run_diff();
      if (first_lvl !== 1'b0) return 0;
      for (int i = 0; i < exp_q.size() || i < run_q.size(); i++) begin
         if (i >= exp_q.size() || i >= run_q.size()) return i;
         if (run_q[i] != exp_q[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [31:0] decode_runs();
      logic [31:0] v;
      v = '0;
      if (run_q.size() < 67 || first_lvl !== 1'b0) return 32'hxxxxxxxx;
      for (int k = 0; k < 32; k++) v[31-k] = (run_q[3 + 2*k] > 20);
      return v;
   endfunction

   // Starts one frame from a point just after a falling edge and records ir_signal until ready.
   task automatic capture(input logic [31:0] c, input logic r, input int inj_a, input int inj_b,
                          input logic [31:0] inj_code);
      int   cur_len;
      logic cur_lvl;
      run_q.delete();
      done_cnt   = 0;
      done_tick  = 0;
      ready_tick = 0;
      cur_len    = 0;
      cur_lvl    = 1'b1;
      first_lvl  = 1'bx;
      code  = c;
      rpt   = r;
      start = 1'b1;
      for (int t = 1; t <= 4000; t++) begin
         @(negedge nec_clk);
         if (t == 1) begin
            start = 1'b0;
            code  = ~c;
            rpt   = ~r;
         end
         if (t == inj_a || t == inj_b) begin
            start = 1'b1;
            code  = inj_code;
            rpt   = 1'b1;
         end else if (t == inj_a + 1 || t == inj_b + 1) begin
            start = 1'b0;
         end
         if (ready === 1'b1) begin
            ready_tick = t;
            break;
         end
         if (done === 1'b1) begin
            done_cnt++;
            done_tick = t;
         end
         if (t == 1) begin
            first_lvl = ir_signal;
            cur_lvl   = ir_signal;
            cur_len   = 1;
         end else if (ir_signal === cur_lvl) begin
            cur_len++;
         end else begin
            run_q.push_back(cur_len);
            cur_lvl = ir_signal;
            cur_len = 1;
         end
      end
      if (cur_len > 0) run_q.push_back(cur_len);
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      rpt   = 1'b0;
      code  = '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge nec_clk);
         nchecks++;
         if ({ir_signal, ready, done} !== 3'b110)
            begin nerrors++; $display("FAIL reset_hold cyc=%0d got ir/ready/done=%b exp=110", i, {ir_signal, ready, done}); end
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge nec_clk);
         nchecks++;
         if ({ir_signal, ready, done} !== 3'b110)
            begin nerrors++; $display("FAIL reset_release cyc=%0d got ir/ready/done=%b exp=110", i, {ir_signal, ready, done}); end
      end
      $display("test_reset: ir=%b ready=%b done=%b", ir_signal, ready, done);
   endtask

   task automatic test_data_frame();
      int d;
      capture(32'h20DF6A95, 1'b0, 0, 0, 32'h0);
      build_expected(32'h20DF6A95, 1'b0);
      d = first_run_diff();
      nchecks++;
      if (d != -1) begin nerrors++; $display("FAIL data_runs idx=%0d got=%0d exp=%0d", d, get_run(d), get_exp(d)); end
      nchecks++;
      if (get_run(0) != 160 || get_run(1) != 80)
         begin nerrors++; $display("FAIL data_leader got=%0d/%0d exp=160/80", get_run(0), get_run(1)); end
      nchecks++;
      if (get_run(2) != 10 || get_run(3) != 10 || get_run(6) != 10 || get_run(7) != 30)
         begin nerrors++; $display("FAIL data_bits got b31=%0d/%0d b29=%0d/%0d exp 10/10 10/30", get_run(2), get_run(3), get_run(6), get_run(7)); end
      nchecks++;
      if (done_cnt != 1 || done_tick != 1210)
         begin nerrors++; $display("FAIL data_done got cnt=%0d tick=%0d exp cnt=1 tick=1210", done_cnt, done_tick); end
      nchecks++;
      if (ready_tick != 1922) begin nerrors++; $display("FAIL data_ready got=%0d exp=1922", ready_tick); end
      nchecks++;
      if (decode_runs() !== 32'h20DF6A95) begin nerrors++; $display("FAIL data_decode got=%h exp=20df6a95", decode_runs()); end
      $display("test_data_frame: code=20df6a95 done_tick=%0d ready_tick=%0d", done_tick, ready_tick);
   endtask

   task automatic test_back_to_back();
      logic [31:0] codes [4];
      logic [31:0] got;
      int          exp_len;
      codes[0] = 32'h20DF6A95;
      codes[1] = 32'h20DFEA15;
      codes[2] = 32'h20DF1AE5;
      codes[3] = 32'h20DF9A65;
      for (int i = 0; i < 4; i++) begin
         capture(codes[i], 1'b0, 0, 0, 32'h0);
         got     = decode_runs();
         exp_len = 890 + 20 * $countones(codes[i]);
         nchecks++;
         if (got !== codes[i]) begin nerrors++; $display("FAIL b2b_decode n=%0d got=%h exp=%h", i, got, codes[i]); end
         nchecks++;
         if (done_tick != exp_len || done_cnt != 1)
            begin nerrors++; $display("FAIL b2b_done n=%0d got tick=%0d cnt=%0d exp tick=%0d cnt=1", i, done_tick, done_cnt, exp_len); end
         nchecks++;
         if (ready_tick != exp_len + 712)
            begin nerrors++; $display("FAIL b2b_period n=%0d got=%0d exp=%0d", i, ready_tick, exp_len + 712); end
         $display("test_back_to_back: n=%0d code=%h decoded=%h period=%0d", i, codes[i], got, ready_tick);
      end
   endtask

   task automatic test_repeat();
      int d;
      capture(32'hFFFFFFFF, 1'b1, 0, 0, 32'h0);
      build_expected(32'hFFFFFFFF, 1'b1);
      d = first_run_diff();
      nchecks++;
      if (d != -1) begin nerrors++; $display("FAIL rpt_runs idx=%0d got=%0d exp=%0d", d, get_run(d), get_exp(d)); end
      nchecks++;
      if (run_q.size() != 4) begin nerrors++; $display("FAIL rpt_nruns got=%0d exp=4", run_q.size()); end
      nchecks++;
      if (done_cnt != 1 || done_tick != 210)
         begin nerrors++; $display("FAIL rpt_done got cnt=%0d tick=%0d exp cnt=1 tick=210", done_cnt, done_tick); end
      nchecks++;
      if (ready_tick != 922) begin nerrors++; $display("FAIL rpt_ready got=%0d exp=922", ready_tick); end
      $display("test_repeat: done_tick=%0d ready_tick=%0d runs=%0d", done_tick, ready_tick, run_q.size());
   endtask

   task automatic test_ignore_start();
      int d;
      capture(32'h20DF6A95, 1'b0, 500, 1500, 32'h12345678);
      build_expected(32'h20DF6A95, 1'b0);
      d = first_run_diff();
      nchecks++;
      if (d != -1) begin nerrors++; $display("FAIL ignore_runs idx=%0d got=%0d exp=%0d", d, get_run(d), get_exp(d)); end
      nchecks++;
      if (decode_runs() !== 32'h20DF6A95) begin nerrors++; $display("FAIL ignore_decode got=%h exp=20df6a95", decode_runs()); end
      nchecks++;
      if (done_cnt != 1 || done_tick != 1210 || ready_tick != 1922)
         begin nerrors++; $display("FAIL ignore_timing got cnt=%0d done=%0d ready=%0d exp 1/1210/1922", done_cnt, done_tick, ready_tick); end
      $display("test_ignore_start: decoded=%h ready_tick=%0d", decode_runs(), ready_tick);
   endtask

   task automatic test_lengths();
      capture(32'h00000000, 1'b0, 0, 0, 32'h0);
      nchecks++;
      if (done_tick != 890 || ready_tick != 1602 || decode_runs() !== 32'h0)
         begin nerrors++; $display("FAIL len_zeros got done=%0d ready=%0d code=%h exp 890/1602/00000000", done_tick, ready_tick, decode_runs()); end
      $display("test_lengths: zeros done_tick=%0d", done_tick);
      capture(32'hFFFFFFFF, 1'b0, 0, 0, 32'h0);
      nchecks++;
      if (done_tick != 1530 || ready_tick != 2242 || decode_runs() !== 32'hFFFFFFFF)
         begin nerrors++; $display("FAIL len_ones got done=%0d ready=%0d code=%h exp 1530/2242/ffffffff", done_tick, ready_tick, decode_runs()); end
      $display("test_lengths: ones done_tick=%0d", done_tick);
   endtask

   // Tick 253 falls in the space of bit 31, tick 245 in its mark.
   task automatic test_reset_midframe(input int stop_tick);
      code  = 32'h20DF6A95;
      rpt   = 1'b0;
      start = 1'b1;
      @(negedge nec_clk);
      start = 1'b0;
      repeat (stop_tick - 1) @(negedge nec_clk);
      nchecks++;
      if (ready !== 1'b0) begin nerrors++; $display("FAIL midrst_busy t=%0d got ready=%b exp=0", stop_tick, ready); end
      reset = 1'b1;
      #1;
      nchecks++;
      if ({ir_signal, ready, done} !== 3'b110)
         begin nerrors++; $display("FAIL midrst_async t=%0d got ir/ready/done=%b exp=110", stop_tick, {ir_signal, ready, done}); end
      repeat (3) @(negedge nec_clk);
      reset = 1'b0;
      repeat (3) @(negedge nec_clk);
      nchecks++;
      if ({ir_signal, ready, done} !== 3'b110)
         begin nerrors++; $display("FAIL midrst_release t=%0d got ir/ready/done=%b exp=110", stop_tick, {ir_signal, ready, done}); end
      $display("test_reset_midframe: t=%0d ir=%b ready=%b", stop_tick, ir_signal, ready);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      rpt   = 1'b0;
      code  = '0;
      test_reset();
      test_data_frame();
      test_repeat();
      test_ignore_start();
      test_lengths();
      test_reset_midframe(253);
      test_reset_midframe(245);
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
